exmem_pipe_stage: RTL and testbench

Parametrised EX/MEM pipeline stage with valid/ready flow control, a one-entry skid buffer and synchronous flush. It sits between the execute stage and the data-memory stage. It carries the control bundle, destination register, ALU result and store data. Stalls back-pressure cleanly without combinational ready paths, and flushes turn the stage into bubbles with all control bits forced low.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_slot.sv | 70 +++++++
 rtl/exmem_pipe_stage.sv | 190 +++++++++++++++++++
 tb/tb_exmem_pipe_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline stage: control bundle, default widths
// and the occupancy state encoding.
package pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 4;
    localparam int CTRL_W_DEF = 7;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic call;
        logic mem_to_reg;
        logic ret_future;
        logic halt;
    } pipe_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control bundle and payload. The control
// output is gated by valid so an empty slot can never request a write.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  pipe_ctrl_t        d_ctrl,
    input  logic [RD_W-1:0]   d_rd,
    input  logic [DATA_W-1:0] d_alu,
    input  logic [DATA_W-1:0] d_sdata,
    output logic              q_valid,
    output pipe_ctrl_t        q_ctrl,
    output logic [RD_W-1:0]   q_rd,
    output logic [DATA_W-1:0] q_alu,
    output logic [DATA_W-1:0] q_sdata
);

    logic              valid_r;
    pipe_ctrl_t        ctrl_r;
    logic [RD_W-1:0]   rd_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] sdata_r;

    // Valid and control: clear wins over load so flush always produces a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end else if (clr) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= d_ctrl;
        end else begin
            valid_r <= valid_r;
            ctrl_r  <= ctrl_r;
        end
    end

    // Payload is only reset, never cleared by flush; bubbles keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_r    <= '0;
            alu_r   <= '0;
            sdata_r <= '0;
        end else if (load && !clr) begin
            rd_r    <= d_rd;
            alu_r   <= d_alu;
            sdata_r <= d_sdata;
        end else begin
            rd_r    <= rd_r;
            alu_r   <= alu_r;
            sdata_r <= sdata_r;
        end
    end

    assign q_valid = valid_r;
    assign q_ctrl  = valid_r ? ctrl_r : '0;
    assign q_rd    = rd_r;
    assign q_alu   = alu_r;
    assign q_sdata = sdata_r;

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM stage with a main slot and a skid slot behind a registered in_ready.
// Optional PIPE_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module exmem_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_sdata
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    pipe_state_e       state_r, next_state_s;
    logic              in_ready_r;
    logic              xfer_in_s, xfer_out_s;
    logic              main_load_s, main_clr_s, main_from_skid_s;
    logic              skid_load_s, skid_clr_s;

    pipe_ctrl_t        in_ctrl_s;
    pipe_ctrl_t        main_d_ctrl_s, main_ctrl_s, skid_ctrl_s;
    logic [RD_W-1:0]   main_d_rd_s, skid_rd_s;
    logic [DATA_W-1:0] main_d_alu_s, main_d_sdata_s, skid_alu_s, skid_sdata_s;
    logic              main_valid_s, skid_valid_s;

    assign in_ctrl_s  = in_ctrl;
    assign xfer_in_s  = in_valid & in_ready_r;
    assign xfer_out_s = main_valid_s & out_ready;

    // State register and registered in_ready derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s != FULL);
        end
    end

    // Next-state logic; flush overrides every transfer.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY:   next_state_s = xfer_in_s ? ONE : EMPTY;
                ONE: begin
                    if (xfer_in_s && !xfer_out_s) begin
                        next_state_s = FULL;
                    end else if (!xfer_in_s && xfer_out_s) begin
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                FULL:    next_state_s = out_ready ? ONE : FULL;
                default: next_state_s = EMPTY;
            endcase
        end
    end

    // Slot control decoded from the current state and handshakes.
    always_comb begin
        main_load_s      = 1'b0;
        main_clr_s       = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clr_s       = 1'b0;
        if (flush) begin
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: main_load_s = xfer_in_s;
                ONE: begin
                    if (xfer_in_s && xfer_out_s) begin
                        main_load_s = 1'b1;
                    end else if (xfer_in_s) begin
                        skid_load_s = 1'b1;
                    end else if (xfer_out_s) begin
                        main_clr_s = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                default: begin
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    assign main_d_ctrl_s  = main_from_skid_s ? skid_ctrl_s  : in_ctrl_s;
    assign main_d_rd_s    = main_from_skid_s ? skid_rd_s    : in_rd;
    assign main_d_alu_s   = main_from_skid_s ? skid_alu_s   : in_alu;
    assign main_d_sdata_s = main_from_skid_s ? skid_sdata_s : in_sdata;

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (main_clr_s),
        .load    (main_load_s),
        .d_ctrl  (main_d_ctrl_s),
        .d_rd    (main_d_rd_s),
        .d_alu   (main_d_alu_s),
        .d_sdata (main_d_sdata_s),
        .q_valid (main_valid_s),
        .q_ctrl  (main_ctrl_s),
        .q_rd    (out_rd),
        .q_alu   (out_alu),
        .q_sdata (out_sdata)
    );

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (skid_clr_s),
        .load    (skid_load_s),
        .d_ctrl  (in_ctrl_s),
        .d_rd    (in_rd),
        .d_alu   (in_alu),
        .d_sdata (in_sdata),
        .q_valid (skid_valid_s),
        .q_ctrl  (skid_ctrl_s),
        .q_rd    (skid_rd_s),
        .q_alu   (skid_alu_s),
        .q_sdata (skid_sdata_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_s;
    assign out_ctrl  = main_ctrl_s;

`ifdef PIPE_PERF_EN
    logic [15:0] stall_cnt_r, bubble_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= 16'h0000;
            bubble_cnt_r <= 16'h0000;
        end else begin
            if (main_valid_s && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (!main_valid_s && (bubble_cnt_r != 16'hFFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 16'h0001;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Scoreboard bench for exmem_pipe_stage: a queue-based occupancy model of the
// stage predicts in_ready, out_valid and the presented entry every cycle.
module tb_exmem_pipe_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int CTRL_W = 7;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [RD_W-1:0]   in_rd, out_rd;
    logic [DATA_W-1:0] in_alu, in_sdata, out_alu, out_sdata;
`ifdef PIPE_PERF_EN
    logic [15:0]       stall_cnt, bubble_cnt;
    int                m_stall, m_bubble;
`endif

    entry_t exp_q[$];
    bit     model_ready = 1'b1;
    bit     mon_en      = 1'b0;
    int     errors      = 0;
    int     checks      = 0;

    always #5 clk = ~clk;

    exmem_pipe_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_alu    (in_alu),
        .in_sdata  (in_sdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_alu   (out_alu),
        .out_sdata (out_sdata)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO holding at most two entries; flush/rst empty it.
    always @(posedge clk) begin
        entry_t e;
        bit     acc;
        bit     had;
        e   = '{ctrl: in_ctrl, rd: in_rd, alu: in_alu, sdata: in_sdata};
        had = (exp_q.size() > 0);
        if (rst) begin
            exp_q.delete();
            model_ready = 1'b1;
`ifdef PIPE_PERF_EN
            m_stall  = 0;
            m_bubble = 0;
`endif
        end else begin
`ifdef PIPE_PERF_EN
            if (had && !out_ready && m_stall < 65535) m_stall++;
            if (!had && m_bubble < 65535) m_bubble++;
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && model_ready;
                if (had && out_ready) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(e);
            end
            model_ready = (exp_q.size() < 2);
        end
    end

    // Monitor: compare what the stage presents against the model's head entry.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                chk("out_ctrl", {57'd0, out_ctrl}, {57'd0, exp_q[0].ctrl});
                chk("out_rd", {60'd0, out_rd}, {60'd0, exp_q[0].rd});
                chk("out_alu", {48'd0, out_alu}, {48'd0, exp_q[0].alu});
                chk("out_sdata", {48'd0, out_sdata}, {48'd0, exp_q[0].sdata});
            end else begin
                chk("bubble_ctrl", {57'd0, out_ctrl}, 64'd0);
            end
`ifdef PIPE_PERF_EN
            chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
            chk("bubble_cnt", {48'd0, bubble_cnt}, 64'(m_bubble));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                         input bit ordy, input bit fl, input bit r);
        in_valid  = v;
        in_ctrl   = c;
        in_rd     = a[3:0];
        in_alu    = a;
        in_sdata  = ~a;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_ctrl"}, {57'd0, out_ctrl}, 64'd0);
        chk({tag, "_rd"}, {60'd0, out_rd}, 64'd0);
        chk({tag, "_alu"}, {48'd0, out_alu}, 64'd0);
        chk({tag, "_sdata"}, {48'd0, out_sdata}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_rd = '0; in_alu = '0; in_sdata = '0;
        repeat (2) tick();
        chk_reset_vals("reset");
        mon_en = 1'b1;

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) drive(1'b1, 7'h40, 16'(i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Stall absorbed by the skid slot, then drain
        drive(1'b1, 7'h10, 16'hA000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h10, 16'hA001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h10, 16'hA002, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_hold_alu", {48'd0, out_alu}, 64'h0000_0000_0000_A000);
        for (int i = 0; i < 4; i++) drive(1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with mem_write set in both slots
        drive(1'b1, 7'h20, 16'hB000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h20, 16'hB001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h20, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ctrl", {57'd0, out_ctrl}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Flush and reset together while FULL
        drive(1'b1, 7'h7F, 16'hC000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h7F, 16'hC001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h7F, 16'hC002, 1'b0, 1'b1, 1'b1);
        chk_reset_vals("flush_rst");

        // Reset mid-stall, then a single entry
        drive(1'b1, 7'h08, 16'hD000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'h08, 16'hD001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 7'h44, 16'h00FF, 1'b1, 1'b0, 1'b0);
        chk("post_rst_alu", {48'd0, out_alu}, 64'h0000_0000_0000_00FF);
        drive(1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 7'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 99) == 0));
        end

`ifdef PIPE_PERF_EN
        drive(1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 7'h01, 16'hE000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_5", {48'd0, stall_cnt}, 64'd5);
        for (int i = 0; i < 66000; i++) drive(1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_sat", {48'd0, stall_cnt}, 64'h0000_0000_0000_FFFF);
`endif

        drive(1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
